// File: rtl/port_bank_pkg.sv
// Shared definitions for port_bank: bus op encoding, reset values and the
// masked bit/byte update used by every register write path.
package port_bank_pkg;

  localparam logic [2:0] OP_IDLE     = 3'd0;
  localparam logic [2:0] OP_WR_LATCH = 3'd1;
  localparam logic [2:0] OP_RD_PORT  = 3'd2;
  localparam logic [2:0] OP_WR_DIR   = 3'd3;
  localparam logic [2:0] OP_WR_IE    = 3'd4;
  localparam logic [2:0] OP_CLR_FLAG = 3'd5;
  localparam logic [2:0] OP_RD_FLAG  = 3'd6;

  localparam logic [7:0] PORT_LATCH_RESET = 8'hFF;

  // Byte access replaces the register; bit access writes bin into every
  // position bit and holds the rest (position = 0 leaves cur untouched).
  function automatic logic [7:0] masked_update(input logic       bb,
                                               input logic [7:0] position,
                                               input logic [7:0] cur,
                                               input logic [7:0] din,
                                               input logic       bin);
    if (bb) begin
      return din;
    end
    return (cur & ~position) | (position & {8{bin}});
  endfunction

endpackage

// File: rtl/port_bank_if.sv
// Internal-bus access path shared by all ports of port_bank.
interface port_bank_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned WIDTH     = 8
);
  localparam int unsigned SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [2:0]       op;
  logic [SEL_W-1:0] sel;
  logic             Bb;
  logic [WIDTH-1:0] position;
  logic             rmw;
  logic [WIDTH-1:0] din;
  logic             bin;
  logic [WIDTH-1:0] dout;
  logic             bout;
  logic             rd_valid;

  modport master (
    output op, sel, Bb, position, rmw, din, bin,
    input  dout, bout, rd_valid
  );

  modport slave (
    input  op, sel, Bb, position, rmw, din, bin,
    output dout, bout, rd_valid
  );
endinterface

// File: rtl/port_pin_sync.sv
// Pad input synchroniser for one port, with an edge-history register that
// yields a one-cycle falling-edge pulse per bit.
module port_pin_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] hist_q;

  // Reset to ones so an idle-high pad does not look like a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '1;
      end
      hist_q <= '1;
    end else begin
      stage_q[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      hist_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];
  assign fall = hist_q & ~sync;

endmodule

// File: rtl/port_bank.sv
// Bank of NUM_PORTS 8051-style I/O ports sharing one bus access path, with
// per-port falling-edge flags and interrupt requests.
module port_bank
  import port_bank_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  port_bank_if.slave                 bus,
  input  logic [NUM_PORTS*WIDTH-1:0] pin_in,
  output logic [NUM_PORTS*WIDTH-1:0] pin_out,
  output logic [NUM_PORTS*WIDTH-1:0] pin_oe,
  output logic [NUM_PORTS-1:0]       irq
);

  localparam int unsigned SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef logic [WIDTH-1:0] word_t;

  word_t latch_q [NUM_PORTS];
  word_t latch_d [NUM_PORTS];
  word_t dir_q   [NUM_PORTS];
  word_t dir_d   [NUM_PORTS];
  word_t ie_q    [NUM_PORTS];
  word_t ie_d    [NUM_PORTS];
  word_t flag_q  [NUM_PORTS];
  word_t flag_d  [NUM_PORTS];
  word_t sync    [NUM_PORTS];
  word_t fall    [NUM_PORTS];

  logic [7:0] pos8;
  logic [7:0] din8;
  logic       sel_ok;
  word_t      src;
  word_t      dout_d, dout_q;
  logic       bout_d, bout_q;
  logic       rd_valid_d, rd_valid_q;

  function automatic word_t apply(input logic       bb,
                                  input logic [7:0] pos,
                                  input logic [7:0] din,
                                  input logic       bin,
                                  input word_t      cur);
    logic [7:0] cur8;
    logic [7:0] res8;
    cur8             = '0;
    cur8[WIDTH-1:0]  = cur;
    res8             = masked_update(bb, pos, cur8, din, bin);
    return res8[WIDTH-1:0];
  endfunction

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    port_pin_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .pin   (pin_in[p*WIDTH +: WIDTH]),
      .sync  (sync[p]),
      .fall  (fall[p])
    );

    assign pin_out[p*WIDTH +: WIDTH] = latch_q[p];
    assign pin_oe[p*WIDTH +: WIDTH]  = dir_q[p];
    assign irq[p]                    = |(flag_q[p] & ie_q[p]);
  end

  always_comb begin
    pos8            = '0;
    pos8[WIDTH-1:0] = bus.position;
    din8            = '0;
    din8[WIDTH-1:0] = bus.din;
    sel_ok          = (32'(bus.sel) < NUM_PORTS);
    src             = '0;

    for (int p = 0; p < NUM_PORTS; p++) begin
      latch_d[p] = latch_q[p];
      dir_d[p]   = dir_q[p];
      ie_d[p]    = ie_q[p];
      flag_d[p]  = flag_q[p] | fall[p];

      if (sel_ok && (bus.sel == SEL_W'(p))) begin
        case (bus.op)
          OP_WR_LATCH: latch_d[p] = apply(bus.Bb, pos8, din8, bus.bin, latch_q[p]);
          OP_WR_DIR:   dir_d[p]   = apply(bus.Bb, pos8, din8, bus.bin, dir_q[p]);
          OP_WR_IE:    ie_d[p]    = apply(bus.Bb, pos8, din8, bus.bin, ie_q[p]);
          // Clear first, then OR the new edges back in so a coincident set wins.
          OP_CLR_FLAG: flag_d[p]  = (flag_q[p] & ~apply(bus.Bb, pos8, din8, 1'b1, '0))
                                    | fall[p];
          default: ;
        endcase
        src = (bus.op == OP_RD_FLAG) ? flag_q[p] : (bus.rmw ? latch_q[p] : sync[p]);
      end
    end

    rd_valid_d = (bus.op == OP_RD_PORT) || (bus.op == OP_RD_FLAG);
    dout_d     = rd_valid_d ? src : dout_q;
    bout_d     = rd_valid_d ? (!bus.Bb && |(src & bus.position)) : bout_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        latch_q[p] <= PORT_LATCH_RESET[WIDTH-1:0];
        dir_q[p]   <= '0;
        ie_q[p]    <= '0;
        flag_q[p]  <= '0;
      end
      dout_q     <= '0;
      bout_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        latch_q[p] <= latch_d[p];
        dir_q[p]   <= dir_d[p];
        ie_q[p]    <= ie_d[p];
        flag_q[p]  <= flag_d[p];
      end
      dout_q     <= dout_d;
      bout_q     <= bout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.bout     = bout_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_port_bank.sv
// Directed bench for port_bank: a 4-port instance for the main behaviour and
// a 3-port instance for out-of-range select handling.
module tb_port_bank;
  import port_bank_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  port_bank_if #(.NUM_PORTS(4), .WIDTH(8)) bus4 ();
  port_bank_if #(.NUM_PORTS(3), .WIDTH(8)) bus3 ();

  logic [31:0] pin_in4, pin_out4, pin_oe4;
  logic [3:0]  irq4;
  logic [23:0] pin_in3, pin_out3, pin_oe3;
  logic [2:0]  irq3;

  port_bank #(.NUM_PORTS(4), .WIDTH(8), .SYNC_STAGES(2)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus4.slave),
    .pin_in  (pin_in4),
    .pin_out (pin_out4),
    .pin_oe  (pin_oe4),
    .irq     (irq4)
  );

  port_bank #(.NUM_PORTS(3), .WIDTH(8), .SYNC_STAGES(2)) dut3 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus3.slave),
    .pin_in  (pin_in3),
    .pin_out (pin_out3),
    .pin_oe  (pin_oe3),
    .irq     (irq3)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [2:0] op, input logic [1:0] sel, input logic bb,
                        input logic [7:0] pos, input logic rmw, input logic [7:0] din,
                        input logic bin);
    bus4.op       = op;
    bus4.sel      = sel;
    bus4.Bb       = bb;
    bus4.position = pos;
    bus4.rmw      = rmw;
    bus4.din      = din;
    bus4.bin      = bin;
  endtask

  task automatic drive3(input logic [2:0] op, input logic [1:0] sel, input logic rmw,
                        input logic [7:0] din);
    bus3.op       = op;
    bus3.sel      = sel;
    bus3.Bb       = 1'b1;
    bus3.position = 8'h00;
    bus3.rmw      = rmw;
    bus3.din      = din;
    bus3.bin      = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    pin_in4 = '1;
    pin_in3 = '1;
    drive4(OP_IDLE, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    drive3(OP_IDLE, 2'd0, 1'b0, 8'h00);
    step();
    step();
    reset = 1'b1;

    // Writes land, then a reset mid-cycle aborts a pending read.
    drive4(OP_WR_LATCH, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("wr_latch_byte", {24'h0, pin_out4[7:0]}, 32'h00);
    drive4(OP_WR_DIR, 2'd0, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0);
    step();
    check("wr_dir_byte", {24'h0, pin_oe4[7:0]}, 32'hFF);
    drive4(OP_RD_PORT, 2'd0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("rst_pin_out", pin_out4, 32'hFFFF_FFFF);
    check("rst_pin_oe", pin_oe4, 32'h0);
    check("rst_irq", {28'h0, irq4}, 32'h0);
    check("rst_rd_valid", {31'h0, bus4.rd_valid}, 32'h0);
    step();
    check("rst_no_rd_valid", {31'h0, bus4.rd_valid}, 32'h0);
    reset = 1'b1;
    drive4(OP_RD_PORT, 2'd2, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    step();
    check("rd_p2_valid", {31'h0, bus4.rd_valid}, 32'h1);
    check("rd_p2_dout", {24'h0, bus4.dout}, 32'hFF);
    check("rd_p2_bout", {31'h0, bus4.bout}, 32'h0);
    drive4(OP_IDLE, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("rd_valid_pulse", {31'h0, bus4.rd_valid}, 32'h0);

    // Bit writes and bit reads on port 1.
    drive4(OP_WR_DIR, 2'd1, 1'b1, 8'h00, 1'b0, 8'h0F, 1'b0);
    step();
    drive4(OP_WR_LATCH, 2'd1, 1'b0, 8'h08, 1'b0, 8'hAA, 1'b0);
    step();
    check("bit_wr_out", {24'h0, pin_out4[15:8]}, 32'hF7);
    check("bit_wr_oe", {24'h0, pin_oe4[15:8]}, 32'h0F);
    drive4(OP_RD_PORT, 2'd1, 1'b0, 8'h08, 1'b1, 8'h00, 1'b0);
    step();
    check("bit_rd_b3", {31'h0, bus4.bout}, 32'h0);
    check("bit_rd_dout", {24'h0, bus4.dout}, 32'hF7);
    drive4(OP_RD_PORT, 2'd1, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0);
    step();
    check("bit_rd_b0", {31'h0, bus4.bout}, 32'h1);
    drive4(OP_WR_LATCH, 2'd1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("bit_wr_pos0", {24'h0, pin_out4[15:8]}, 32'hF7);
    drive4(3'd7, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("op7_no_write", {24'h0, pin_out4[7:0]}, 32'hFF);
    check("op7_no_read", {31'h0, bus4.rd_valid}, 32'h0);

    // Pin read latency on port 0; the A5 pattern also drops bits 1,3,4,6.
    drive4(OP_IDLE, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    pin_in4[7:0] = 8'hA5;
    step();
    drive4(OP_RD_PORT, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("pin_rd_early", {24'h0, bus4.dout}, 32'hFF);
    step();
    check("pin_rd_late", {24'h0, bus4.dout}, 32'hA5);
    check("pin_rd_b2b_valid", {31'h0, bus4.rd_valid}, 32'h1);
    drive4(OP_RD_FLAG, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("flag_p0", {24'h0, bus4.dout}, 32'h5A);
    drive4(OP_CLR_FLAG, 2'd0, 1'b0, 8'h02, 1'b0, 8'h00, 1'b0);
    step();
    drive4(OP_RD_FLAG, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("flag_p0_bitclr", {24'h0, bus4.dout}, 32'h58);
    check("irq_p0_masked", {31'h0, irq4[0]}, 32'h0);

    // Edge capture and interrupt on port 3 bit 0.
    drive4(OP_WR_IE, 2'd3, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0);
    step();
    drive4(OP_IDLE, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    pin_in4[24] = 1'b0;
    step();
    check("irq3_e1", {31'h0, irq4[3]}, 32'h0);
    step();
    check("irq3_e2", {31'h0, irq4[3]}, 32'h0);
    step();
    check("irq3_e3", {31'h0, irq4[3]}, 32'h1);
    drive4(OP_RD_FLAG, 2'd3, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0);
    step();
    check("flag3_bit", {31'h0, bus4.bout}, 32'h1);
    drive4(OP_CLR_FLAG, 2'd3, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0);
    step();
    check("irq3_clr", {31'h0, irq4[3]}, 32'h0);

    // Falling edge lands in the same cycle as its clear: set wins.
    drive4(OP_IDLE, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    pin_in4[24] = 1'b1;
    step();
    step();
    step();
    check("irq3_no_rise_edge", {31'h0, irq4[3]}, 32'h0);
    pin_in4[24] = 1'b0;
    step();
    step();
    drive4(OP_CLR_FLAG, 2'd3, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0);
    step();
    check("set_wins_irq", {31'h0, irq4[3]}, 32'h1);
    drive4(OP_RD_FLAG, 2'd3, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("set_wins_flag", {24'h0, bus4.dout}, 32'h01);
    drive4(OP_WR_IE, 2'd3, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    check("ie_off_irq", {31'h0, irq4[3]}, 32'h0);

    // Out-of-range select on the 3-port instance.
    drive4(OP_IDLE, 2'd0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    drive3(OP_WR_LATCH, 2'd3, 1'b0, 8'h00);
    step();
    check("oor_wr", {8'h0, pin_out3}, 32'h00FF_FFFF);
    drive3(OP_RD_PORT, 2'd3, 1'b1, 8'h00);
    step();
    check("oor_rd_valid", {31'h0, bus3.rd_valid}, 32'h1);
    check("oor_rd_dout", {24'h0, bus3.dout}, 32'h00);
    drive3(OP_WR_LATCH, 2'd2, 1'b0, 8'h3C);
    step();
    check("p3_inrange_wr", {8'h0, pin_out3}, 32'h003C_FFFF);
    drive3(OP_IDLE, 2'd0, 1'b0, 8'h00);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/port_bank.md
# port_bank

Parametrised successor to the four fixed 8-bit port SFRs in the MCU51 top level. It holds NUM_PORTS I/O ports of WIDTH bits each. Each port has an output latch, a direction register, a pin synchroniser, falling-edge capture flags and a per-port interrupt request. All ports share one internal-bus access path with byte/bit addressing and 8051 read-modify-write semantics. Pad tristating stays in the top level: this block exports pin_out and pin_oe.

## Interface
- NUM_PORTS, 4, number of ports (1..8)
- WIDTH, 8, bits per port (1..8); bit selection uses WIDTH
- SYNC_STAGES, 2, pin synchroniser depth (>=2)
- clk  input  1  core clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- op  input  3  bus operation: 0 IDLE, 1 WR_LATCH, 2 RD_PORT, 3 WR_DIR, 4 WR_IE, 5 CLR_FLAG, 6 RD_FLAG, 7 reserved (treated as IDLE)
- sel  input  $clog2(NUM_PORTS) (min 1)  port select
- Bb  input  1  1 byte access, 0 bit access
- position  input  WIDTH  one-hot bit select, used when Bb=0
- rmw  input  1  RD_PORT source: 1 output latch, 0 synchronised pins
- din  input  WIDTH  byte write data
- bin  input  1  bit write data
- dout  output  WIDTH  registered read data
- bout  output  1  registered bit read data
- rd_valid  output  1  dout/bout valid this cycle
- pin_in  input  NUM_PORTS*WIDTH  raw pad inputs, port p at [p*WIDTH +: WIDTH]
- pin_out  output  NUM_PORTS*WIDTH  output latches
- pin_oe  output  NUM_PORTS*WIDTH  direction registers, 1 = drive
- irq  output  NUM_PORTS  per-port request, |(flag & ie)

## Operation
- One op per cycle, acting on port sel. If sel >= NUM_PORTS, writes are ignored and reads return 0 with rd_valid=1.
- WR_LATCH / WR_DIR / WR_IE
  - Bb=1: whole register <= din.
  - Bb=0: every bit set in position <= bin; other bits are held.
  - position=0 with Bb=0 is a no-op.
- RD_PORT
  - Source is the latch when rmw=1, otherwise the last synchroniser stage.
  - dout = whole source byte.
  - bout = |(source & position) when Bb=0; bout = 0 when Bb=1.
- RD_FLAG: same formatting as RD_PORT, with the flag register as source.
- CLR_FLAG
  - Write-1-to-clear using din (Bb=1) or position (Bb=0, bin ignored).
  - A flag set by an edge in the same cycle as its clear stays set (set wins).
- Edge capture
  - A flag bit sets when the synchronised pin is 1 in the previous cycle and 0 in the current cycle.
  - Capture applies regardless of direction, so output bits see their own driven level.
- irq is combinational from the flag and ie registers.
- Reset values:
  - latch all ones (8051 port reset value)
  - dir, ie, flags all zero (all pins input)
  - synchroniser stages and edge history all ones
  - dout 0, bout 0, rd_valid 0
- Reset asserted mid-operation aborts any op. Reads pending at reset produce no rd_valid.

## Timing
- Writes take effect at the rising edge that samples op. pin_out and pin_oe change in the same cycle the register updates.
- Reads: rd_valid, dout and bout are registered, valid exactly 1 cycle after op=RD_*. rd_valid is a single-cycle pulse and there is no backpressure. Back-to-back reads give one result per cycle.
- A read issued the cycle after a write to the same register returns the new value. There is no same-cycle bypass (a single op per cycle makes it impossible).
- Pin to RD_PORT (rmw=0) latency: a pad change is visible in the synchroniser output SYNC_STAGES edges later.
- Pin falling edge to flag set: SYNC_STAGES+1 edges. irq asserts in the same cycle as the flag, if enabled.
- RD_FLAG in the cycle a flag sets returns the pre-set value.
- ie changes affect irq the cycle after the write.

## Structure
- Shared package port_bank_pkg holds:
  - op encoding constants OP_IDLE..OP_RD_FLAG
  - PORT_LATCH_RESET (all ones)
  - a function computing the masked bit/byte update from Bb, position, din and bin, reused by the three write ops and CLR_FLAG
- Sub-module port_pin_sync (WIDTH, SYNC_STAGES): synchroniser chain plus edge-history register. Outputs the synchronised pins and a falling-edge pulse vector. Instantiated once per port by a generate loop.

## Test plan
- Reset: drive reset low mid-write → pin_out all ones, pin_oe = 0, irq = 0, rd_valid = 0. Release, then RD_PORT rmw=1 on port 2 → dout = 8'hFF after 1 cycle.
- Bit write:
  - WR_DIR port 1 byte 8'h0F, then WR_LATCH Bb=0, position = 8'h08, bin = 0 → pin_out[15:8] = 8'hF7, pin_oe[15:8] = 8'h0F.
  - RD_PORT Bb=0, position = 8'h08, rmw=1 → bout = 0.
- Pin read latency: set pin_in port 0 = 8'hA5 → RD_PORT rmw=0 returns 8'hA5 only when issued ≥ SYNC_STAGES cycles after the change. A read issued 1 cycle after the change returns the old value.
- Edge and IRQ:
  - WR_IE port 3 = 8'h01, then take pin_in[24] from 1 to 0 → flag bit 0 and irq[3] set after 3 edges.
  - CLR_FLAG din = 8'h01 → irq[3] falls the next cycle.
  - A falling edge coincident with the clear leaves the flag set.
- Out-of-range select: NUM_PORTS=3, sel=3, WR_LATCH 8'h00 → no pin_out change. RD_PORT → dout = 0, rd_valid = 1.
